// File: rtl/blood_pkg.sv
// Shared definitions for the blood-type entry stage and the compatibility checker.
package blood_pkg;

    // Blood-type code shared with the downstream compatibility logic.
    typedef enum logic [1:0] {
        BT_O  = 2'b00,
        BT_A  = 2'b01,
        BT_B  = 2'b10,
        BT_AB = 2'b11
    } blood_t;

    typedef enum logic [1:0] {
        S_DONOR = 2'd0,
        S_RECIP = 2'd1,
        S_DONE  = 2'd2
    } entry_state_t;

    localparam logic [2:0] LED_DONOR = 3'b001;
    localparam logic [2:0] LED_RECIP = 3'b010;
    localparam logic [2:0] LED_DONE  = 3'b100;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debounce counter.
module sw_debounce #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);

    localparam int unsigned CW = (COUNT < 2) ? 1 : $clog2(COUNT + 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt;

    // Stable value follows the synchronised input only after COUNT differing samples in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(COUNT - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/blood_type_entry.sv
// Debounced two-step donor/recipient entry for the blood-type checker.
// Define SIM_FAST_DEBOUNCE_EN to force a 4-cycle debounce for simulation.
module blood_type_entry
    import blood_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw_pin,
    input  logic       btn_confirm,
    input  logic       btn_clear,
    output logic [1:0] donor_type,
    output logic [1:0] recip_type,
    output logic       pair_valid,
    output logic       pair_strobe,
    output logic [2:0] state_led
);

`ifdef SIM_FAST_DEBOUNCE_EN
    localparam int unsigned DEBOUNCE_CYCLES = 4;
`else
    localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
`endif

    logic [1:0]   w_sw_donor;
    logic [1:0]   w_sw_recip;
    logic         w_cfm_stable;
    logic         w_clr_stable;
    logic         w_unused_sw;

    logic         r_cfm_prev;
    logic         r_clr_prev;
    logic         r_cfm_press;
    logic         r_clr_press;

    entry_state_t r_state;
    blood_t       r_donor;
    blood_t       r_recip;
    logic         r_valid;
    logic         r_strobe;
    logic [2:0]   r_led;

    assign w_unused_sw = ^sw_pin[5:2];

    sw_debounce #(.WIDTH(2), .COUNT(DEBOUNCE_CYCLES)) u_db_donor (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (sw_pin[1:0]),
        .o_stable (w_sw_donor)
    );

    sw_debounce #(.WIDTH(2), .COUNT(DEBOUNCE_CYCLES)) u_db_recip (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (sw_pin[7:6]),
        .o_stable (w_sw_recip)
    );

    sw_debounce #(.WIDTH(1), .COUNT(DEBOUNCE_CYCLES)) u_db_confirm (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (btn_confirm),
        .o_stable (w_cfm_stable)
    );

    sw_debounce #(.WIDTH(1), .COUNT(DEBOUNCE_CYCLES)) u_db_clear (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (btn_clear),
        .o_stable (w_clr_stable)
    );

    // Registered rising-edge detect: one press per stable button rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfm_prev  <= 1'b0;
            r_clr_prev  <= 1'b0;
            r_cfm_press <= 1'b0;
            r_clr_press <= 1'b0;
        end else begin
            r_cfm_prev  <= w_cfm_stable;
            r_clr_prev  <= w_clr_stable;
            r_cfm_press <= w_cfm_stable & ~r_cfm_prev;
            r_clr_press <= w_clr_stable & ~r_clr_prev;
        end
    end

    // Entry sequence; clear takes priority over a coincident confirm.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_DONOR;
            r_donor  <= BT_O;
            r_recip  <= BT_O;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
            r_led    <= LED_DONOR;
        end else begin
            r_strobe <= 1'b0;
            if (r_clr_press) begin
                r_state <= S_DONOR;
                r_donor <= BT_O;
                r_recip <= BT_O;
                r_valid <= 1'b0;
                r_led   <= LED_DONOR;
            end else if (r_cfm_press) begin
                case (r_state)
                    S_DONOR: begin
                        r_donor <= blood_t'(w_sw_donor);
                        r_state <= S_RECIP;
                        r_led   <= LED_RECIP;
                    end
                    S_RECIP: begin
                        r_recip  <= blood_t'(w_sw_recip);
                        r_valid  <= 1'b1;
                        r_strobe <= 1'b1;
                        r_state  <= S_DONE;
                        r_led    <= LED_DONE;
                    end
                    S_DONE: begin
                        r_donor <= blood_t'(w_sw_donor);
                        r_valid <= 1'b0;
                        r_state <= S_RECIP;
                        r_led   <= LED_RECIP;
                    end
                    default: begin
                        r_state <= S_DONOR;
                        r_led   <= LED_DONOR;
                    end
                endcase
            end
        end
    end

    assign donor_type  = r_donor;
    assign recip_type  = r_recip;
    assign pair_valid  = r_valid;
    assign pair_strobe = r_strobe;
    assign state_led   = r_led;

endmodule
